// File: rtl/step_sequencer.sv
// SAP1 controller front end: instruction register, micro-step counter and ALU flags,
// with run / pause / single-step / halted sequencing that gates the datapath clock-enable.
module step_sequencer #(
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int INSTRUCTION_STEPS = 8,
    parameter int DATA_WIDTH        = 8,
    localparam int STEP_WIDTH       = $clog2(INSTRUCTION_STEPS),
    localparam int OPERAND_WIDTH    = DATA_WIDTH - INSTRUCTION_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_run,
    input  logic                         i_step_req,
    input  logic [DATA_WIDTH-1:0]        i_bus,
    input  logic                         i_instrregi,
    input  logic                         i_adv,
    input  logic                         i_halt,
    input  logic                         i_alulatchf,
    input  logic                         i_alu_zero,
    input  logic                         i_alu_carry,
    input  logic                         i_alu_odd,
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [OPERAND_WIDTH-1:0]     o_operand,
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic                         o_zero,
    output logic                         o_carry,
    output logic                         o_odd,
    output logic                         o_clk_en,
    output logic                         o_halted,
    output logic                         o_step_overflow
);

    localparam logic [1:0] ST_PAUSE  = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(INSTRUCTION_STEPS - 1);
    localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic                  step_req_q;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [2:0]            flags_q, flags_d;
    logic                  halted_q, halted_d;
    logic                  overflow_q, overflow_d;
    logic                  step_pulse_s;
    logic                  clk_en_s;

    // Enable depends only on registered state and the step request, never on decoder controls.
    always_comb begin
        step_pulse_s = i_step_req & ~step_req_q;
        clk_en_s     = (state_q == ST_RUN) | ((state_q == ST_PAUSE) & step_pulse_s);
    end

    // Mode sequencing; an enabled halt wins over any run/pause change.
    always_comb begin
        state_d = state_q;
        if (clk_en_s && i_halt) begin
            state_d = ST_HALTED;
        end else begin
            case (state_q)
                ST_PAUSE:  state_d = i_run ? ST_RUN : ST_PAUSE;
                ST_RUN:    state_d = i_run ? ST_RUN : ST_PAUSE;
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_HALTED;
            endcase
        end
        halted_d = (state_d == ST_HALTED);
    end

    // Micro-step counter: halt holds, adv restarts, running off the end wraps and flags it.
    always_comb begin
        step_d     = step_q;
        overflow_d = overflow_q;
        if (clk_en_s) begin
            if (i_halt) begin
                step_d = step_q;
            end else if (i_adv) begin
                step_d = '0;
            end else if (step_q == STEP_LAST) begin
                step_d     = '0;
                overflow_d = 1'b1;
            end else begin
                step_d = step_q + STEP_ONE;
            end
        end else begin
            step_d = step_q;
        end
    end

    // IR and flag loads are independent of the step logic so II alongside adv applies both.
    always_comb begin
        ir_d    = ir_q;
        flags_d = flags_q;
        if (clk_en_s && i_instrregi) begin
            ir_d = i_bus;
        end else begin
            ir_d = ir_q;
        end
        if (clk_en_s && i_alulatchf) begin
            flags_d = {i_alu_zero, i_alu_carry, i_alu_odd};
        end else begin
            flags_d = flags_q;
        end
    end

    // Edge register resets high so a request held through reset is not taken as a step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_PAUSE;
            step_req_q <= 1'b1;
            step_q     <= '0;
            ir_q       <= '0;
            flags_q    <= 3'b000;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_req_q <= i_step_req;
            step_q     <= step_d;
            ir_q       <= ir_d;
            flags_q    <= flags_d;
            halted_q   <= halted_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_instruction   = ir_q[DATA_WIDTH-1 -: INSTRUCTION_WIDTH];
    assign o_operand       = ir_q[OPERAND_WIDTH-1:0];
    assign o_step          = step_q;
    assign o_zero          = flags_q[2];
    assign o_carry         = flags_q[1];
    assign o_odd           = flags_q[0];
    assign o_clk_en        = clk_en_s;
    assign o_halted        = halted_q;
    assign o_step_overflow = overflow_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed table and corner sequences plus random stimulus,
// all checked every cycle against a mode/step reference model.
module tb_step_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0, step_req = 1'b0;
    logic [7:0] bus = 8'h00;
    logic       ii = 1'b0, adv = 1'b0, halt = 1'b0, el = 1'b0;
    logic       alu_z = 1'b0, alu_c = 1'b0, alu_o = 1'b0;
    logic [3:0] instr, operand;
    logic [2:0] step;
    logic       zero, carry, odd, clk_en, halted, ovf;

    step_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step_req(step_req), .i_bus(bus),
        .i_instrregi(ii), .i_adv(adv), .i_halt(halt), .i_alulatchf(el),
        .i_alu_zero(alu_z), .i_alu_carry(alu_c), .i_alu_odd(alu_o),
        .o_instruction(instr), .o_operand(operand), .o_step(step),
        .o_zero(zero), .o_carry(carry), .o_odd(odd), .o_clk_en(clk_en),
        .o_halted(halted), .o_step_overflow(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       run, req;
        logic [7:0] bus;
        logic       ii, adv, halt, el, z, c, o;
    } in_t;

    typedef struct {
        in_t        in;
        logic [2:0] exp_step;
        logic       exp_en;
        logic [7:0] exp_ir;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=pause 1=run 2=halted
    int m_mode, m_step, m_ir, m_flags;
    bit m_ovf, m_prev;
    in_t cur = '0;

    function automatic in_t mk(input logic r, input logic q, input logic [7:0] b,
                               input logic i, input logic a, input logic h, input logic e);
        in_t v = '0;
        v.run = r; v.req = q; v.bus = b; v.ii = i; v.adv = a; v.halt = h; v.el = e;
        return v;
    endfunction

    function automatic bit m_en(input logic req_now);
        return (m_mode == 1) || (m_mode == 0 && req_now && !m_prev);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_ir = 0; m_flags = 0; m_ovf = 1'b0; m_prev = 1'b1;
    endtask

    task automatic model_update();
        bit en;
        int nxt;
        en = m_en(cur.req);
        if (en) begin
            if (cur.ii) m_ir = int'(cur.bus);
            if (cur.el) m_flags = int'({cur.z, cur.c, cur.o});
            if (!cur.halt) begin
                nxt = m_step + 1;
                if (cur.adv) m_step = 0;
                else if (nxt == 8) begin m_step = 0; m_ovf = 1'b1; end
                else m_step = nxt;
            end
        end
        if (en && cur.halt) m_mode = 2;
        else if (m_mode == 0 && cur.run) m_mode = 1;
        else if (m_mode == 1 && !cur.run) m_mode = 0;
        m_prev = cur.req;
    endtask

    task automatic check_model();
        chk("clk_en", {31'd0, clk_en}, {31'd0, m_en(cur.req)});
        chk("step", {29'd0, step}, m_step);
        chk("ir", {24'd0, instr, operand}, m_ir);
        chk("flags", {29'd0, zero, carry, odd}, m_flags);
        chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
        chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
    endtask

    task automatic drive(input in_t v);
        @(negedge clk);
        cur = v;
        run = v.run; step_req = v.req; bus = v.bus; ii = v.ii; adv = v.adv;
        halt = v.halt; el = v.el; alu_z = v.z; alu_c = v.c; alu_o = v.o;
        #1;
        check_model();
    endtask

    task automatic edge_();
        @(posedge clk);
        model_update();
    endtask

    task automatic cycle(input in_t v);
        drive(v);
        edge_();
    endtask

    task automatic cycle_en(input in_t v, output logic e);
        drive(v);
        e = clk_en;
        edge_();
    endtask

    task automatic do_reset(input bit async_mid);
        if (async_mid) #3;
        else @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("rst_outputs", {15'd0, instr, operand, step, zero, carry, odd, clk_en, halted, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        edge_();
    endtask

    function automatic in_t rnd_in(input logic r);
        in_t v;
        v.run  = r;
        v.req  = 1'($urandom_range(0, 1));
        v.bus  = 8'($urandom);
        v.ii   = 1'($urandom_range(0, 1));
        v.adv  = ($urandom_range(0, 3) == 0);
        v.halt = ($urandom_range(0, 39) == 0);
        v.el   = 1'($urandom_range(0, 1));
        v.z    = 1'($urandom_range(0, 1));
        v.c    = 1'($urandom_range(0, 1));
        v.o    = 1'($urandom_range(0, 1));
        return v;
    endfunction

    initial begin
        vec_t tbl[7];
        in_t  v;
        logic e;
        logic rrun;
        int   cnt, n;

        model_reset();
        tbl[0] = '{mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 1'b0, 8'h00};
        tbl[1] = '{mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 1'b1, 8'h00};
        tbl[2] = '{mk(1'b1, 1'b0, 8'h1A, 1'b1, 1'b0, 1'b0, 1'b0), 3'd1, 1'b1, 8'h00};
        tbl[3] = '{mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 3'd2, 1'b1, 8'h1A};
        tbl[4] = '{mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 3'd3, 1'b1, 8'h1A};
        tbl[5] = '{mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 3'd4, 1'b1, 8'h1A};
        tbl[6] = '{mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0), 3'd0, 1'b1, 8'h1A};

        // Run-mode fetch: II at step 1, adv at step 4
        do_reset(1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].in);
            chk($sformatf("t1_step[%0d]", i), {29'd0, step}, {29'd0, tbl[i].exp_step});
            chk($sformatf("t1_en[%0d]", i), {31'd0, clk_en}, {31'd0, tbl[i].exp_en});
            chk($sformatf("t1_ir[%0d]", i), {24'd0, instr, operand}, {24'd0, tbl[i].exp_ir});
            edge_();
        end
        drive(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("t1_instr", {28'd0, instr}, 32'h1);
        chk("t1_operand", {28'd0, operand}, 32'hA);
        edge_();

        // Single-step pulses, then a level held high
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cycle_en(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), e); cnt += int'(e);
            for (int j = 0; j < 3; j++) begin
                cycle_en(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), e); cnt += int'(e);
            end
        end
        chk("t2_pulse_count", cnt, 32'd3);
        chk("t2_step", {29'd0, step}, 32'd3);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            cycle_en(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), e); cnt += int'(e);
        end
        chk("t2_level_count", cnt, 32'd1);
        chk("t2_level_step", {29'd0, step}, 32'd4);

        // Flag latch at step 4, then hold while EL=0
        cycle(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        v = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        v.z = 1'b1; v.c = 1'b0; v.o = 1'b1;
        cycle(v);
        for (int k = 0; k < 6; k++) begin
            v = rnd_in(1'b0);
            v.req = 1'b0; v.el = 1'b0;
            drive(v);
            chk("t3_flags", {29'd0, zero, carry, odd}, 32'd5);
            edge_();
        end
        chk("t3_step", {29'd0, step}, 32'd5);

        // Halt at step 2
        cycle(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        do_reset(1'b0);
        n = 0;
        while (m_mode != 2 && n < 20) begin
            cycle(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, m_step == 2, 1'b0));
            n++;
        end
        if (m_mode != 2) chk("t4_halt_timeout", 32'd0, 32'd1);
        drive(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("t4_halted", {31'd0, halted}, 32'd1);
        chk("t4_step", {29'd0, step}, 32'd2);
        edge_();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cycle_en(rnd_in(1'($urandom_range(0, 1))), e); cnt += int'(e);
        end
        chk("t4_en_after_halt", cnt, 32'd0);
        chk("t4_step_held", {29'd0, step}, 32'd2);
        do_reset(1'b0);

        // Eight enabled cycles without adv wrap the step and stick the overflow flag
        cnt = 0; n = 0;
        while (cnt < 8 && n < 12) begin
            if (m_en(1'b0)) cnt++;
            cycle(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
            n++;
        end
        chk("t5_wrap_budget", cnt, 32'd8);
        drive(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("t5_overflow", {31'd0, ovf}, 32'd1);
        chk("t5_step", {29'd0, step}, 32'd0);
        edge_();
        for (int k = 0; k < 10; k++) begin
            v = rnd_in(1'b1);
            v.halt = 1'b0;
            drive(v);
            chk("t5_overflow_sticky", {31'd0, ovf}, 32'd1);
            edge_();
        end

        // Async reset at step 3 with step request held high
        cycle(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        do_reset(1'b0);
        cycle(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            cycle(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
            if (k < 2) cycle(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        drive(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("t6_step_before", {29'd0, step}, 32'd3);
        edge_();
        do_reset(1'b1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            cycle_en(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), e); cnt += int'(e);
        end
        chk("t6_no_spurious_step", cnt, 32'd0);
        chk("t6_step_after", {29'd0, step}, 32'd0);

        // Random traffic against the model
        rrun = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 7) == 0) rrun = ~rrun;
                cycle(rnd_in(rrun));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
